// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// Revision: 1.0
`default_nettype none

package mem_arb_pkg;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

  localparam int BURST_W           = 4;
  localparam int MAX_BURST_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot grant selection, m0 first unless the burst limit hands the slot to m1.
// Revision: 1.0
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       force_m1,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (m0_req && !(force_m1 && m1_req)) begin
      gnt[PORT_M0] = 1'b1;
    end else if (m1_req) begin
      gnt[PORT_M1] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arb.sv
// mem_arb: two-requester single-port memory arbiter with bounded m0 bursts and read-return routing.
// Revision: 1.0
`default_nettype none

module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_wm,
  input  logic [31:0] mem_rd
);

  logic [BURST_W-1:0] burst_cnt;
  logic               force_m1;
  logic [1:0]         pick_gnt;
  logic               m0_rv_q;
  logic               m1_rv_q;
  logic               unused_addr_lsb;

  assign force_m1 = (burst_cnt == BURST_W'(MAX_BURST));

  mem_arb_pick u_pick (
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .force_m1 (force_m1),
    .gnt      (pick_gnt)
  );

  // Grants are suppressed while reset is held so every output reads zero.
  assign m0_gnt = pick_gnt[PORT_M0] & ~reset;
  assign m1_gnt = pick_gnt[PORT_M1] & ~reset;

  assign unused_addr_lsb = ^{m0_addr[1:0], m1_addr[1:0]};

  always_comb begin
    mem_we = 1'b0;
    mem_a  = 32'h0;
    mem_wd = 32'h0;
    mem_wm = 4'h0;
    if (m0_gnt) begin
      mem_we = m0_we;
      mem_a  = {m0_addr[31:2], 2'b00};
      mem_wd = m0_wdata;
      mem_wm = m0_we ? m0_wmask : 4'h0;
    end else if (m1_gnt) begin
      mem_we = m1_we;
      mem_a  = {m1_addr[31:2], 2'b00};
      mem_wd = m1_wdata;
      mem_wm = m1_we ? m1_wmask : 4'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (m1_gnt || !m1_req) begin
      burst_cnt <= '0;
    end else if (m0_gnt) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Memory returns read data one cycle after the address; route it to whoever was granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rv_q <= 1'b0;
      m1_rv_q <= 1'b0;
    end else begin
      m0_rv_q <= m0_gnt & ~m0_we;
      m1_rv_q <= m1_gnt & ~m1_we;
    end
  end

  assign m0_rvalid = m0_rv_q;
  assign m1_rvalid = m1_rv_q;
  assign m0_rdata  = m0_rv_q ? mem_rd : 32'h0;
  assign m1_rdata  = m1_rv_q ? mem_rd : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb; stimulus queues expected grants/read returns, a monitor checks them.
// Revision: 1.0
`default_nettype none

module tb_mem_arb;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  wm;
  } rq_t;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  wm;
  } exp_gnt_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_rv_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd;
  logic [3:0]  mem_wm;
  logic [31:0] mem_rd = 32'h0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit done  = 0;
  exp_gnt_t gq[$];
  exp_rv_t  rq[$];

  mem_arb #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_wm(mem_wm), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdfun(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Registered memory: data for the address presented this cycle appears next cycle.
  always @(posedge clk) begin
    mem_rd <= rdfun(mem_a);
    cyc    <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rq_t mk(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] wm);
    rq_t r;
    r.req = req; r.we = we; r.addr = addr; r.wd = wd; r.wm = wm;
    return r;
  endfunction

  // exp_port: 0 = m0 granted, 1 = m1 granted, -1 = no grant; no_rv drops the read return.
  task automatic drive(input rq_t a, input rq_t b, input int exp_port, input bit no_rv);
    rq_t g;
    m0_req = a.req; m0_we = a.we; m0_addr = a.addr; m0_wdata = a.wd; m0_wmask = a.wm;
    m1_req = b.req; m1_we = b.we; m1_addr = b.addr; m1_wdata = b.wd; m1_wmask = b.wm;
    if (exp_port >= 0) begin
      g = (exp_port == 0) ? a : b;
      gq.push_back('{port: exp_port, we: g.we, a: g.addr, wd: g.wd, wm: g.we ? g.wm : 4'h0});
      if (!g.we && !no_rv)
        rq.push_back('{port: exp_port, data: rdfun(g.addr), due: cyc + 1});
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!done && !reset) begin
      exp_gnt_t eg;
      exp_rv_t  er;
      if (m0_gnt && m1_gnt) chk("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'h0);
      if (m0_gnt || m1_gnt) begin
        if (gq.size() == 0) chk("gnt_unexpected", {m1_gnt, m0_gnt}, 32'h0);
        else begin
          eg = gq.pop_front();
          chk("gnt_port", {m1_gnt, m0_gnt}, (eg.port == 0) ? 32'h1 : 32'h2);
          chk("mem_we", 32'(mem_we), 32'(eg.we));
          chk("mem_a", mem_a, eg.a);
          chk("mem_wd", mem_wd, eg.wd);
          chk("mem_wm", 32'(mem_wm), 32'(eg.wm));
        end
      end else begin
        if (gq.size() != 0) begin
          chk("gnt_missing", 32'h0, 32'h1);
          void'(gq.pop_front());
        end
        chk("idle_mem", {mem_we, mem_wm, mem_a[23:0]}, 32'h0);
        chk("idle_wd", mem_wd, 32'h0);
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0) chk("rv_unexpected", {m1_rvalid, m0_rvalid}, 32'h0);
        else begin
          er = rq.pop_front();
          chk("rv_port", {m1_rvalid, m0_rvalid}, (er.port == 0) ? 32'h1 : 32'h2);
          chk("rv_data", (er.port == 0) ? m0_rdata : m1_rdata, er.data);
        end
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
        chk("rv_missing", 32'h0, 32'h1);
        void'(rq.pop_front());
      end
      if (!m0_rvalid) chk("m0_rdata_zero", m0_rdata, 32'h0);
      if (!m1_rvalid) chk("m1_rdata_zero", m1_rdata, 32'h0);
    end
  end

  rq_t idle;

  initial begin
    idle   = mk(0, 0, 32'h0, 32'h0, 4'h0);
    reset  = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = 32'h0; m0_wmask = 4'hF;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55; m1_wmask = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {m1_gnt, m0_gnt}, 32'h0);
    chk("rst_mem", {mem_we, mem_wm, mem_a[23:0]}, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    chk("rst_rv", {m1_rvalid, m0_rvalid}, 32'h0);
    chk("rst_cnt", 32'(dut.burst_cnt), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;

    // Single m0 read, response next cycle
    drive(mk(1, 0, 32'h10, 32'h0, 4'hF), idle, 0, 0);
    drive(idle, idle, -1, 0);
    // m1 partial write
    drive(idle, mk(1, 1, 32'h24, 32'h11223344, 4'b0010), 1, 0);
    drive(idle, idle, -1, 0);
    // Back-to-back reads from different requesters
    drive(mk(1, 0, 32'h40, 32'h0, 4'h0), idle, 0, 0);
    drive(idle, mk(1, 0, 32'h44, 32'h0, 4'hC), 1, 0);
    drive(idle, idle, -1, 0);
    // Zero-mask write passes through
    drive(mk(1, 1, 32'h50, 32'hCAFEF00D, 4'h0), idle, 0, 0);
    // m0 priority, then m1 once m0 drops
    drive(mk(1, 1, 32'h80, 32'h12345678, 4'h9), mk(1, 0, 32'h84, 32'h0, 4'hF), 0, 0);
    drive(idle, mk(1, 0, 32'h84, 32'h0, 4'hF), 1, 0);
    drive(idle, idle, -1, 0);

    // Continuous contention: m0 x4 then m1, twice
    for (int i = 0; i < 10; i++)
      drive(mk(1, 1, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF),
            mk(1, 0, 32'h200 + 32'(4 * i), 32'h0, 4'h3),
            (i % 5 == 4) ? 1 : 0, 0);
    drive(idle, idle, -1, 0);

    // Reset in the cycle after a granted read drops the in-flight response
    drive(mk(1, 0, 32'h300, 32'h0, 4'hF), mk(1, 0, 32'h304, 32'h0, 4'hF), 0, 0);
    drive(mk(1, 0, 32'h308, 32'h0, 4'hF), mk(1, 0, 32'h30C, 32'h0, 4'hF), 0, 1);
    chk("cnt_before_rst", 32'(dut.burst_cnt), 32'h2);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("midrst_cnt", 32'(dut.burst_cnt), 32'h0);
    chk("midrst_gnt", {m1_gnt, m0_gnt}, 32'h0);
    chk("midrst_rv", {m1_rvalid, m0_rvalid}, 32'h0);
    chk("midrst_mem", {mem_we, mem_wm, mem_a[23:0]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; m1_req = 1'b0;
    drive(mk(1, 0, 32'h10, 32'h0, 4'hF), idle, 0, 0);

    // Idle
    drive(idle, idle, -1, 0);
    drive(idle, idle, -1, 0);
    @(negedge clk); #1;
    chk("idle_gnt", {m1_gnt, m0_gnt}, 32'h0);
    chk("idle_mem_final", {mem_we, mem_wm, mem_a[23:0]}, 32'h0);
    chk("gq_drained", 32'(gq.size()), 32'h0);
    chk("rq_drained", 32'(rq.size()), 32'h0);
    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive m0 grants while m1 is waiting (legal range 1..15).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock shared with the memory.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port m0_req, input, 1 bit: requester 0 (CPU data) access request.
REQ-006 SHALL have port m0_we, input, 1 bit: requester 0 write (1) or read (0).
REQ-007 SHALL have port m0_addr, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port m0_wdata, input, 32 bits: write data.
REQ-009 SHALL have port m0_wmask, input, 4 bits: byte write enables, bit i covering byte lane [8i+7:8i].
REQ-010 SHALL have port m0_gnt, output, 1 bit: request accepted this cycle.
REQ-011 SHALL have port m0_rvalid, output, 1 bit: read data valid this cycle.
REQ-012 SHALL have port m0_rdata, output, 32 bits: read data.
REQ-013 SHALL have ports m1_req, m1_we, m1_addr, m1_wdata, m1_wmask, m1_gnt, m1_rvalid and m1_rdata for requester 1 (loader/DMA), identical in direction, width and meaning to the m0 ports.
REQ-014 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-015 SHALL have port mem_a, output, 32 bits: memory address.
REQ-016 SHALL have port mem_wd, output, 32 bits: memory write data.
REQ-017 SHALL have port mem_wm, output, 4 bits: memory byte mask.
REQ-018 SHALL have port mem_rd, input, 32 bits: memory read data, registered in the memory and valid one cycle after the address.

Function
REQ-019 SHALL grant at most one requester per cycle; mN_gnt is combinational from the mN_req ports and registered state, and the transfer occurs at the clock edge where mN_req and mN_gnt are both 1.
REQ-020 SHALL give m0 priority by default, granting m1 only when m0_req=0 or the burst counter forces it.
REQ-021 SHALL keep a burst counter that increments on each m0 grant while m1_req=1 and clears when m1 is granted or m1_req=0.
REQ-022 SHALL grant m1 instead of m0 when both request and the burst counter equals MAX_BURST.
REQ-023 SHALL drive mem_a, mem_we, mem_wd and mem_wm combinationally from the granted requester's signals.
REQ-024 SHALL force mem_wm=0 for a granted read.
REQ-025 SHALL drive mem_a=0, mem_we=0, mem_wd=0 and mem_wm=0 when no grant is given.
REQ-026 SHALL pass a write with wmask=0 through unchanged, as a no-op write.
REQ-027 SHALL register mN_rvalid as (mN_gnt AND NOT mN_we), so it is high exactly one cycle after a granted read.
REQ-028 SHALL drive mN_rdata = mem_rd when mN_rvalid=1 and 0 otherwise.
REQ-029 SHALL accept back-to-back requests every cycle, for full throughput of 1 access per cycle.
REQ-030 SHALL NOT let a response pending for one requester block a new grant to the other.
REQ-031 SHALL allow a requester to drop mN_req without being granted; there is no penalty and no state change except the counter clear of REQ-021.

Reset
REQ-032 SHALL, while reset=1, force all outputs to 0 and clear the burst counter and both rvalid registers.
REQ-033 SHALL discard any read response still in flight when reset asserts mid-operation; no rvalid follows after reset deasserts.
REQ-034 SHALL make its first grant possible in the first cycle after reset deasserts.

Structure
REQ-035 SHALL place the port-index typedef, the counter width constant BURST_W=4 and the MAX_BURST default in package mem_arb_pkg.
REQ-036 SHALL implement grant selection as the single combinational sub-module mem_arb_pick, taking inputs m0_req, m1_req and the force signal and producing the one-hot grant.
REQ-037 SHALL keep the counter, the rvalid pipeline and the output muxing in mem_arb.

Verification
REQ-038 SHALL cover: m0 only reads addr 0x10 (mem_rd=0xDEADBEEF) -> m0_gnt=1 in the same cycle, m0_rvalid=1 with m0_rdata=0xDEADBEEF in the next cycle, and m1_rvalid=0 throughout.
REQ-039 SHALL cover: m0 and m1 requesting continuously with MAX_BURST=4 -> grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1 repeating.
REQ-040 SHALL cover: an m1 write to 0x24 with wdata=0x11223344 and wmask=4'b0010 -> mem_we=1, mem_a=0x24, mem_wm=4'b0010, and no rvalid.
REQ-041 SHALL cover: an m0 read in cycle N followed by an m1 read in cycle N+1 -> m0_rvalid in cycle N+1 and m1_rvalid in cycle N+2, each carrying its own mem_rd.
REQ-042 SHALL cover: reset asserted in the cycle after a granted read -> rvalid stays 0, all mem_* outputs are 0, and the counter reads 0.
REQ-043 SHALL cover: no requests -> mem_we=0, mem_wm=0, mem_a=0, and both gnt outputs 0.
